// File: rtl/tile_cfg_pkg.sv
// Shared types and sizing helpers for the double-buffered tile configuration memory.
package tile_cfg_pkg;

    typedef enum logic {
        RB_IDLE = 1'b0,
        RB_RESP = 1'b1
    } rbState_t;

    // Width of a frame index; never narrower than one bit.
    function automatic int unsigned frameIdxWidth(input int unsigned maxFrames);
        return (maxFrames > 1) ? 32'($clog2(maxFrames)) : 32'd1;
    endfunction

    // Frames that hold at least one stored config bit.
    function automatic int unsigned usedFrames(input int unsigned noBits,
                                               input int unsigned frameBits);
        return (noBits + frameBits - 1) / frameBits;
    endfunction

endpackage

// File: rtl/cfg_readback_fsm.sv
// Readback channel: snapshots one active or shadow frame on request and holds it
// behind a valid/ready handshake until the consumer accepts it.
module cfg_readback_fsm
    import tile_cfg_pkg::*;
#(
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned NoConfigBits    = 640,
    localparam int unsigned IdxW           = frameIdxWidth(MaxFramesPerCol),
    localparam int unsigned TotalBits      = MaxFramesPerCol * FrameBitsPerRow
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic [TotalBits-1:0]       activeBits,
    input  logic [TotalBits-1:0]       shadowBits,
    input  logic                       rbReq,
    input  logic [IdxW-1:0]            rbFrame,
    input  logic                       rbSel,
    input  logic                       rbReady,
    output logic                       rbValid,
    output logic [FrameBitsPerRow-1:0] rbData,
    output logic                       rbErr
);

    localparam int unsigned UsedFrames = usedFrames(NoConfigBits, FrameBitsPerRow);

    rbState_t                   state;
    rbState_t                   stateNext;
    logic                       inRange_c;
    logic [FrameBitsPerRow-1:0] frameSel_c;
    logic [FrameBitsPerRow-1:0] dataNext;
    logic                       errNext;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= RB_IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            RB_IDLE: if (rbReq)   stateNext = RB_RESP;
            RB_RESP: if (rbReady) stateNext = RB_IDLE;
            default:              stateNext = RB_IDLE;
        endcase
    end

    // Unused frames and indices past the column both report an error with zero data.
    always_comb begin
        inRange_c  = 32'(rbFrame) < UsedFrames;
        frameSel_c = '0;
        for (int unsigned f = 0; f < UsedFrames; f++) begin
            if (32'(rbFrame) == f) begin
                frameSel_c = rbSel ? shadowBits[f*FrameBitsPerRow +: FrameBitsPerRow]
                                   : activeBits[f*FrameBitsPerRow +: FrameBitsPerRow];
            end
        end
    end

    always_comb begin
        dataNext = rbData;
        errNext  = rbErr;
        case (state)
            RB_IDLE: begin
                if (rbReq) begin
                    dataNext = inRange_c ? frameSel_c : '0;
                    errNext  = !inRange_c;
                end
            end
            RB_RESP: begin
                if (rbReady) errNext = 1'b0;
            end
            default: begin
                dataNext = '0;
                errNext  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rbData <= '0;
            rbErr  <= 1'b0;
        end else begin
            rbData <= dataNext;
            rbErr  <= errNext;
        end
    end

    assign rbValid = (state == RB_RESP);

endmodule

// File: rtl/tile_config_mem_dbuf.sv
// Double-buffered tile configuration memory: strobed shadow store, atomic commit to
// the active store, optional frame readback (built only when CFG_READBACK_EN is defined).
module tile_config_mem_dbuf
    import tile_cfg_pkg::*;
#(
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned NoConfigBits    = 640,
    localparam int unsigned IdxW           = frameIdxWidth(MaxFramesPerCol)
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    input  logic                       commit,
    output logic                       pending,
    output logic [NoConfigBits-1:0]    ConfigBits,
    output logic [NoConfigBits-1:0]    ConfigBits_N,
    input  logic                       rb_req,
    input  logic [IdxW-1:0]            rb_frame,
    input  logic                       rb_sel,
    output logic                       rb_valid,
    input  logic                       rb_ready,
    output logic [FrameBitsPerRow-1:0] rb_data,
    output logic                       rb_err
);

    localparam int unsigned UsedFrames = usedFrames(NoConfigBits, FrameBitsPerRow);

    logic [NoConfigBits-1:0]    shadowBits;
    logic [NoConfigBits-1:0]    activeBits;
    logic                       shadowWrite_c;
    logic [MaxFramesPerCol-1:0] unusedStrobe;
    logic [FrameBitsPerRow-1:0] unusedData;

    assign unusedStrobe  = FrameStrobe;
    assign unusedData    = FrameData;
    assign shadowWrite_c = |FrameStrobe[UsedFrames-1:0];

    // One shadow register per used frame; the last frame may be partially stored.
    for (genvar f = 0; f < UsedFrames; f++) begin : gFrame
        localparam int unsigned Lo = f * FrameBitsPerRow;
        localparam int unsigned Wd = (NoConfigBits - Lo < FrameBitsPerRow)
                                     ? NoConfigBits - Lo : FrameBitsPerRow;
        logic [Wd-1:0] frameQ;

        always_ff @(posedge CLK or negedge resetn) begin
            if (!resetn)             frameQ <= '0;
            else if (FrameStrobe[f]) frameQ <= FrameData[Wd-1:0];
        end

        assign shadowBits[Lo +: Wd] = frameQ;
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn)     activeBits <= '0;
        else if (commit) activeBits <= shadowBits;
    end

    // A write in the commit cycle lands after the copy, so the shadow stays dirty.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn)            pending <= 1'b0;
        else if (shadowWrite_c) pending <= 1'b1;
        else if (commit)        pending <= 1'b0;
    end

    assign ConfigBits   = activeBits;
    assign ConfigBits_N = ~activeBits;

`ifdef CFG_READBACK_EN
    localparam int unsigned TotalBits = MaxFramesPerCol * FrameBitsPerRow;

    logic [TotalBits-1:0] activePad;
    logic [TotalBits-1:0] shadowPad;

    always_comb begin
        activePad                  = '0;
        shadowPad                  = '0;
        activePad[NoConfigBits-1:0] = activeBits;
        shadowPad[NoConfigBits-1:0] = shadowBits;
    end

    cfg_readback_fsm #(
        .MaxFramesPerCol (MaxFramesPerCol),
        .FrameBitsPerRow (FrameBitsPerRow),
        .NoConfigBits    (NoConfigBits)
    ) uReadback (
        .clk        (CLK),
        .rstN       (resetn),
        .activeBits (activePad),
        .shadowBits (shadowPad),
        .rbReq      (rb_req),
        .rbFrame    (rb_frame),
        .rbSel      (rb_sel),
        .rbReady    (rb_ready),
        .rbValid    (rb_valid),
        .rbData     (rb_data),
        .rbErr      (rb_err)
    );
`else
    logic unusedRb;

    assign unusedRb = ^{rb_req, rb_frame, rb_sel, rb_ready};
    assign rb_valid = 1'b0;
    assign rb_data  = '0;
    assign rb_err   = 1'b0;
`endif

endmodule

// File: tb/tb_tile_config_mem_dbuf.sv
// Directed bench for tile_config_mem_dbuf: a 640-bit and a 600-bit instance share stimulus.
module tb_tile_config_mem_dbuf;

    logic        CLK;
    logic        resetn;
    logic [31:0] FrameData;
    logic [19:0] FrameStrobe;
    logic        commit;
    logic        rb_req;
    logic [4:0]  rb_frame;
    logic        rb_sel;
    logic        rb_ready;

    logic         pend1, pend2;
    logic [639:0] cfg1, cfgN1;
    logic [599:0] cfg2, cfgN2;
    logic         rbValid1, rbValid2, rbErr1, rbErr2;
    logic [31:0]  rbData1, rbData2;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } item_t;

    item_t expQ[$];
    int    errs   = 0;
    int    checks = 0;

    tile_config_mem_dbuf dut (
        .CLK(CLK), .resetn(resetn), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
        .commit(commit), .pending(pend1), .ConfigBits(cfg1), .ConfigBits_N(cfgN1),
        .rb_req(rb_req), .rb_frame(rb_frame), .rb_sel(rb_sel), .rb_valid(rbValid1),
        .rb_ready(rb_ready), .rb_data(rbData1), .rb_err(rbErr1)
    );

    tile_config_mem_dbuf #(.NoConfigBits(600)) dut2 (
        .CLK(CLK), .resetn(resetn), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
        .commit(commit), .pending(pend2), .ConfigBits(cfg2), .ConfigBits_N(cfgN2),
        .rb_req(rb_req), .rb_frame(rb_frame), .rb_sel(rb_sel), .rb_valid(rbValid2),
        .rb_ready(rb_ready), .rb_data(rbData2), .rb_err(rbErr2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic push(input string tag, input logic [31:0] exp);
        item_t it;
        it.tag = tag;
        it.exp = exp;
        expQ.push_back(it);
    endtask

    task automatic check(input logic [31:0] obs);
        item_t it;
        checks++;
        if (expQ.size() == 0) begin
            errs++;
            $display("FAIL scoreboard_underflow observed=%h expected=queued_item", obs);
        end else begin
            it = expQ.pop_front();
            assert (obs === it.exp) else begin
                errs++;
                $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
            end
        end
    endtask

    initial begin
        resetn = 1'b0; FrameData = '0; FrameStrobe = '0; commit = 1'b0;
        rb_req = 1'b0; rb_frame = '0; rb_sel = 1'b0; rb_ready = 1'b0;
        tick(); tick();

        push("rst_cfg_zero", 32'd1);   check(32'(cfg1 == '0));
        push("rst_cfgn_ones", 32'd1);  check(32'(&cfgN1));
        push("rst_pending", 32'd0);    check(32'(pend1));
        push("rst_rb_valid", 32'd0);   check(32'(rbValid1));
        push("rst_rb_data", 32'd0);    check(rbData1);
        resetn = 1'b1;
        tick();

        // write frame 3, then commit
        FrameStrobe = 20'h00008; FrameData = 32'hDEADBEEF;
        tick();
        FrameStrobe = '0;
        push("f3_pending", 32'd1);       check(32'(pend1));
        push("f3_not_active", 32'd0);    check(cfg1[127:96]);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        push("f3_active", 32'hDEADBEEF); check(cfg1[127:96]);
        push("f3_active_n", 32'h21524110); check(cfgN1[127:96]);
        push("f3_pending_clr", 32'd0);   check(32'(pend1));

        // write in the same cycle as commit
        FrameStrobe = 20'h00001; FrameData = 32'h1;
        tick();
        FrameData = 32'h2; commit = 1'b1;
        tick();
        FrameStrobe = '0; commit = 1'b0;
        push("wc_old_shadow", 32'h1);    check(cfg1[31:0]);
        push("wc_pending", 32'd1);       check(32'(pend1));
        commit = 1'b1;
        tick();
        commit = 1'b0;
        push("wc_second_commit", 32'h2); check(cfg1[31:0]);
        push("wc_pending_clr", 32'd0);   check(32'(pend1));

        // multi-strobe
        FrameStrobe = 20'h00005; FrameData = 32'hA5A5A5A5;
        tick();
        FrameStrobe = '0; commit = 1'b1;
        tick();
        commit = 1'b0;
        push("ms_f0", 32'hA5A5A5A5);     check(cfg1[31:0]);
        push("ms_f1", 32'h0);            check(cfg1[63:32]);
        push("ms_f2", 32'hA5A5A5A5);     check(cfg1[95:64]);
        push("ms_f3", 32'hDEADBEEF);     check(cfg1[127:96]);

`ifdef CFG_READBACK_EN
        // shadow readback of frame 3 under backpressure, frame rewritten meanwhile
        rb_req = 1'b1; rb_sel = 1'b1; rb_frame = 5'd3; rb_ready = 1'b0;
        tick();
        rb_req = 1'b0;
        FrameStrobe = 20'h00008; FrameData = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            push("bp_valid", 32'd1);        check(32'(rbValid1));
            push("bp_data", 32'hDEADBEEF);  check(rbData1);
            if (i == 3) rb_ready = 1'b1;
            tick();
            FrameStrobe = '0;
        end
        rb_ready = 1'b0;
        push("bp_done", 32'd0);             check(32'(rbValid1));

        rb_req = 1'b1; rb_sel = 1'b1; rb_frame = 5'd3;
        tick();
        rb_req = 1'b0;
        push("rb_sh3_valid", 32'd1);        check(32'(rbValid1));
        push("rb_sh3_data", 32'h12345678);  check(rbData1);
        push("rb_sh3_err", 32'd0);          check(32'(rbErr1));
        rb_ready = 1'b1;
        tick();
        rb_ready = 1'b0;

        rb_req = 1'b1; rb_sel = 1'b0; rb_frame = 5'd2;
        tick();
        rb_req = 1'b0;
        push("rb_act2_data", 32'hA5A5A5A5); check(rbData1);
        rb_ready = 1'b1;
        tick();
        rb_ready = 1'b0;
        push("rb_act2_done", 32'd0);        check(32'(rbValid1));
`else
        rb_req = 1'b1; rb_sel = 1'b1; rb_frame = 5'd3; rb_ready = 1'b1;
        tick();
        rb_req = 1'b0; rb_ready = 1'b0;
        push("rb_off_valid", 32'd0);        check(32'(rbValid1));
        push("rb_off_data", 32'd0);         check(rbData1);
        push("rb_off_err", 32'd0);          check(32'(rbErr1));
        FrameStrobe = 20'h00008; FrameData = 32'h12345678;
        tick();
        FrameStrobe = '0;
`endif

        // frame 19 is unused in the 600-bit instance
        commit = 1'b1;
        tick();
        commit = 1'b0;
        push("d2_pending_clr", 32'd0);      check(32'(pend2));
        push("d1_f3_commit", 32'h12345678); check(cfg1[127:96]);
        FrameStrobe = 20'h80000; FrameData = 32'hCAFEF00D;
        tick();
        FrameStrobe = '0;
        push("d2_unused_strobe", 32'd0);    check(32'(pend2));
        push("d1_f19_pending", 32'd1);      check(32'(pend1));

        // partially stored last frame
        FrameStrobe = 20'h40000; FrameData = 32'hFFFFFFFF;
        tick();
        FrameStrobe = '0; commit = 1'b1;
        tick();
        commit = 1'b0;
        push("d2_f18_partial", 32'h00FFFFFF); check(32'(cfg2[599:576]));
        push("d2_f18_n", 32'h0);              check(32'(cfgN2[599:576]));
        push("d1_f18", 32'hFFFFFFFF);         check(cfg1[607:576]);
        push("d1_f19", 32'hCAFEF00D);         check(cfg1[639:608]);

`ifdef CFG_READBACK_EN
        rb_req = 1'b1; rb_sel = 1'b1; rb_frame = 5'd19;
        tick();
        rb_req = 1'b0;
        push("oor_valid", 32'd1);           check(32'(rbValid2));
        push("oor_data", 32'd0);            check(rbData2);
        push("oor_err", 32'd1);             check(32'(rbErr2));
        push("d1_f19_rb", 32'hCAFEF00D);    check(rbData1);
        push("d1_f19_err", 32'd0);          check(32'(rbErr1));
        rb_ready = 1'b1;
        tick();
        rb_ready = 1'b0;
        push("oor_err_clr", 32'd0);         check(32'(rbErr2));
        push("oor_valid_clr", 32'd0);       check(32'(rbValid2));

        rb_req = 1'b1; rb_sel = 1'b0; rb_frame = 5'd18;
        tick();
        rb_req = 1'b0;
        push("d2_f18_rb", 32'h00FFFFFF);    check(rbData2);
        push("d2_f18_rb_err", 32'd0);       check(32'(rbErr2));
`else
        rb_req = 1'b1; rb_sel = 1'b1; rb_frame = 5'd19;
        tick();
        rb_req = 1'b0;
        push("oor_off_valid", 32'd0);       check(32'(rbValid2));
        push("oor_off_err", 32'd0);         check(32'(rbErr2));
`endif

        // asynchronous reset while a readback may be outstanding
        #1 resetn = 1'b0;
        #1;
        push("ar_valid", 32'd0);            check(32'(rbValid1));
        push("ar_cfg_zero", 32'd1);         check(32'(cfg1 == '0));
        push("ar_pending", 32'd0);          check(32'(pend1));
        push("ar_cfgn_ones", 32'd1);        check(32'(&cfgN2));
        tick();
        resetn = 1'b1;
        tick(); tick();
        push("ar_no_replay", 32'd0);        check(32'(rbValid1));
        push("ar_rb_data", 32'd0);          check(rbData1);

        if (expQ.size() != 0) begin
            errs++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
